// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl
// Single-clock pointer and flag controller for a dual-port FIFO storage array.
// Produces write/read addresses, full/empty, occupancy, almost flags and
// sticky overflow/underflow indications. Reads are first-word-fall-through:
// the array's rdata follows raddr combinationally, so the head entry is
// visible whenever rempty is low.
module fifo_sync_ctrl #(
    parameter int ADDR_LINES   = 8,
    parameter int AFULL_LEVEL  = 252,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  clr,
    input  logic                  winc,
    input  logic                  rinc,
    output logic [ADDR_LINES-1:0] waddr,
    output logic [ADDR_LINES-1:0] raddr,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  walmost_full,
    output logic                  ralmost_empty,
    output logic [ADDR_LINES:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ADDR_LINES + 1;
    localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_LEVEL);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          wfull_q, wfull_d;
    logic          rempty_q, rempty_d;
    logic          walmost_full_q, walmost_full_d;
    logic          ralmost_empty_q, ralmost_empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push;
    logic          pop;

    // Next-state pointers and flags; flags come from the next pointers so they
    // are correct in the very cycle after a push/pop edge.
    always_comb begin
        push = winc & ~wfull_q;
        pop  = rinc & ~rempty_q;

        wptr_d      = wptr_q + PW'(push);
        rptr_d      = rptr_q + PW'(pop);
        overflow_d  = overflow_q  | (winc & wfull_q);
        underflow_d = underflow_q | (rinc & rempty_q);

        if (clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        count_d         = wptr_d - rptr_d;
        rempty_d        = (wptr_d == rptr_d);
        wfull_d         = (wptr_d[PW-1] != rptr_d[PW-1]) &&
                          (wptr_d[PW-2:0] == rptr_d[PW-2:0]);
        walmost_full_d  = (count_d >= AFULL_CNT);
        ralmost_empty_d = (count_d <= AEMPTY_CNT);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            rempty_q        <= 1'b1;
            walmost_full_q  <= 1'b0;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            wfull_q         <= wfull_d;
            rempty_q        <= rempty_d;
            walmost_full_q  <= walmost_full_d;
            ralmost_empty_q <= ralmost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    assign waddr         = wptr_q[PW-2:0];
    assign raddr         = rptr_q[PW-2:0];
    assign count         = count_q;
    assign wfull         = wfull_q;
    assign rempty        = rempty_q;
    assign walmost_full  = walmost_full_q;
    assign ralmost_empty = ralmost_empty_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl
// Drives fifo_sync_ctrl with an attached storage array and compares every
// output against a queue-based model of FIFO behaviour after each clock.
module tb_fifo_sync_ctrl;

    localparam int AL    = 3;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;
    localparam int AEMPT = 1;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          clr  = 1'b0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic [7:0]    wdata = 8'h00;
    logic [AL-1:0] waddr, raddr;
    logic          wfull, rempty, walmost_full, ralmost_empty;
    logic [AL:0]   count;
    logic          overflow, underflow;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    rdata;

    int evaluated = 0;
    int failures  = 0;

    byte unsigned q[$];
    bit  mOvf = 1'b0;
    bit  mUnf = 1'b0;
    int  wTotal = 0;
    int  rTotal = 0;

    fifo_sync_ctrl #(
        .ADDR_LINES  (AL),
        .AFULL_LEVEL (AFULL),
        .AEMPTY_LEVEL(AEMPT)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .clr          (clr),
        .winc         (winc),
        .rinc         (rinc),
        .waddr        (waddr),
        .raddr        (raddr),
        .wfull        (wfull),
        .rempty       (rempty),
        .walmost_full (walmost_full),
        .ralmost_empty(ralmost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 wclk = ~wclk;

    // Storage array: write port ignores winc while the controller reports full.
    always @(posedge wclk) begin
        if (winc && !wfull) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evaluated++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int n;
        n = q.size();
        checkVal("count",         32'(count),         32'(n));
        checkVal("rempty",        32'(rempty),        32'(n == 0));
        checkVal("wfull",         32'(wfull),         32'(n == DEPTH));
        checkVal("walmost_full",  32'(walmost_full),  32'(n >= AFULL));
        checkVal("ralmost_empty", 32'(ralmost_empty), 32'(n <= AEMPT));
        checkVal("overflow",      32'(overflow),      32'(mOvf));
        checkVal("underflow",     32'(underflow),     32'(mUnf));
        checkVal("waddr",         32'(waddr),         32'(wTotal % DEPTH));
        checkVal("raddr",         32'(raddr),         32'(rTotal % DEPTH));
        if (n > 0) checkVal("rdata_head", 32'(rdata), 32'(q[0]));
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, update the
    // model for that edge, then check outputs at the following negedge.
    task automatic applyStimulus(input bit r, input bit w, input bit rd,
                                 input bit c, input logic [7:0] d);
        int n;
        wrst  = r;
        winc  = w;
        rinc  = rd;
        clr   = c;
        wdata = d;
        @(posedge wclk);
        n = q.size();
        if (r || c) begin
            q.delete();
            mOvf = 1'b0;
            mUnf = 1'b0;
            wTotal = 0;
            rTotal = 0;
        end else begin
            if (w && n == DEPTH) mOvf = 1'b1;
            if (rd && n == 0)    mUnf = 1'b1;
            if (rd && n > 0) begin
                void'(q.pop_front());
                rTotal++;
            end
            if (w && n < DEPTH) begin
                q.push_back(d);
                wTotal++;
            end
        end
        @(negedge wclk);
        wrst = 1'b0;
        winc = 1'b0;
        rinc = 1'b0;
        clr  = 1'b0;
        checkOutput();
    endtask

    initial begin
        @(negedge wclk);

        // 1. Reset state
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkVal("t1_count", 32'(count), 32'd0);
        checkVal("t1_rempty", 32'(rempty), 32'd1);

        // 2. Fill with 0xA0..0xA7, then one push into a full FIFO
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, 0, 0, 8'hA0 + 8'(i));
            if (i == 4) checkVal("t2_afull_low", 32'(walmost_full), 32'd0);
            if (i == 5) checkVal("t2_afull_high", 32'(walmost_full), 32'd1);
        end
        checkVal("t2_full", 32'(wfull), 32'd1);
        checkVal("t2_count8", 32'(count), 32'd8);
        applyStimulus(0, 1, 0, 0, 8'hFF);
        checkVal("t2_overflow", 32'(overflow), 32'd1);
        checkVal("t2_count_hold", 32'(count), 32'd8);
        checkVal("t2_entry0", 32'(rdata), 32'hA0);

        // 3. Drain in order, then one pop from empty
        for (int i = 0; i < DEPTH; i++) begin
            checkVal("t3_rdata_seq", 32'(rdata), 32'hA0 + 32'(i));
            applyStimulus(0, 0, 1, 0, 8'h00);
            if (i == 6) checkVal("t3_aempty_at1", 32'(ralmost_empty), 32'd1);
        end
        checkVal("t3_empty", 32'(rempty), 32'd1);
        applyStimulus(0, 0, 1, 0, 8'h00);
        checkVal("t3_underflow", 32'(underflow), 32'd1);

        // 4. Steady push+pop at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 8'h30 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 1, 0, 8'($urandom));
            checkVal("t4_count3", 32'(count), 32'd3);
        end

        // 5. Single entry fall-through from empty
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h5C);
        checkVal("t5_rempty", 32'(rempty), 32'd0);
        checkVal("t5_rdata", 32'(rdata), 32'h5C);
        applyStimulus(0, 0, 1, 0, 8'h00);
        checkVal("t5_rempty_after", 32'(rempty), 32'd1);

        // 6. Flush at count 5 together with a write request
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 8'h60 + 8'(i));
        checkVal("t6_count5", 32'(count), 32'd5);
        applyStimulus(0, 1, 0, 1, 8'hEE);
        checkVal("t6_count0", 32'(count), 32'd0);
        checkVal("t6_rempty", 32'(rempty), 32'd1);
        checkVal("t6_underflow_clr", 32'(underflow), 32'd0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 9) < 5),
                          ($urandom_range(0, 39) == 0),
                          8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
